reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle processor.
- Sits directly upstream of the ALU and its shift units. It supplies operand A (rs) and operand B (rt) to the ALU datapath, including the shift amount consumed from B[4:0].
- It is written back from the ALU/memory result at the clock edge.
- Two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 0, 1 = write-through forwarding of same-cycle write data to the read ports; 0 = no forwarding.

Ports:
- clk  input  1  system clock, rising edge active.
- rst  input  1  synchronous, active-high reset.
- raddr1  input  ADDR_W  read port 1 address (rs).
- raddr2  input  ADDR_W  read port 2 address (rt).
- rdata1  output  DATA_W  read port 1 data (ALU operand A).
- rdata2  output  DATA_W  read port 2 data (ALU operand B / shift amount source).
- wen  input  1  write enable.
- waddr  input  ADDR_W  write address (rd/rt).
- wdata  input  DATA_W  write data.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk only.
- Reset: while rst is high at a rising edge, all registers 1..31 are cleared to 32'h0. A write presented in the same cycle is discarded (reset wins). rdata1 and rdata2 read 32'h0 for every address from the cycle after reset onward.
- Write: at a rising edge with rst=0 and wen=1 and waddr!=0, reg[waddr] <= wdata.
  - wen=0 leaves all registers unchanged.
  - waddr=0 is ignored: reg 0 is never stored.
- Read: combinational; rdata = reg[raddr] with zero cycle latency.
  - raddr=0 always returns 32'h0, whatever writes are attempted.
  - Both ports may read the same address simultaneously.
- Read during write to the same address:
  - BYPASS=0: the read returns the old value until the edge, then the new value.
  - BYPASS=1: the read returns wdata in the same cycle when wen=1, waddr==raddr and waddr!=0. This is only legal in pipelined builds; the single-cycle core must use BYPASS=0 to avoid a combinational loop through the ALU.
- No X propagation: every output is defined after the first reset edge.
- Reset mid-operation: an asserted rst overrides any pending write that cycle. The cycle after rst deasserts behaves normally.

Decomposition:
- Shared package cpu_pkg:
  - REG_W=32, REG_ADDR_W=5.
  - Constant REG_ZERO=5'd0.
  - Typedefs reg_addr_t and word_t. The ALU and shifters use the same word_t.
- Sub-module: optional rf_read_port (address decode + zero-register masking + bypass mux), instantiated twice. Everything else stays flat in reg_file.

Test Plan:
- Reset: preload reg5=32'hDEADBEEF, assert rst one cycle with wen=1, waddr=7, wdata=32'h1234 -> rdata1 (raddr1=5) = 0 and rdata2 (raddr2=7) = 0 after the edge.
- Basic write/read: write reg3=32'h00000004 and reg4=32'h80000001 -> raddr1=4, raddr2=3 gives rdata1=32'h80000001, rdata2=32'h00000004 (shift amount 4 feeding the shifter).
- Zero register: wen=1, waddr=0, wdata=32'hFFFFFFFF -> raddr1=0 reads 32'h0 before and after the edge.
- Same-address read/write, BYPASS=0: reg9=32'h11; write 32'h22 to reg9 while raddr1=9 -> rdata1=32'h11 before the edge, 32'h22 after.
- Same-address read/write, BYPASS=1: same stimulus -> rdata1=32'h22 in the same cycle before the edge; raddr2=0 still reads 0.
- wen low: wen=0, waddr=12, wdata=32'hABCD -> reg12 keeps its prior value 32'h0 and both ports show no change.

Source files
------------

// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared datapath widths and types for the single-cycle core
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]      word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// rf_read_port : one asynchronous read port with zero-register masking/bypass
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic w_hit;

  // A write discarded by reset must not be forwarded either.
  assign w_hit = BYPASS && !rst && wen && (waddr == raddr);

  always_comb begin
    rdata = '0;
    if (raddr != ADDR_W'(REG_ZERO)) begin
      rdata = w_hit ? wdata : regs[raddr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : 32 x 32 register file, 2 async read ports, 1 sync write port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Register 0 has no storage; the read ports also mask it.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign regs[i] = '0;
      end else begin : g_store
        always_ff @(posedge clk) begin
          if (rst) begin
            regs[i] <= '0;
          end else if (wen && (waddr == ADDR_W'(i))) begin
            regs[i] <= wdata;
          end
        end
      end
    end
  endgenerate

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd1 (
    .rst   (rst),
    .raddr (raddr1),
    .regs  (regs),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata1)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd2 (
    .rst   (rst),
    .raddr (raddr2),
    .regs  (regs),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .rdata (rdata2)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : directed table plus randomized model check of reg_file
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rd1_nb, rd2_nb, rd1_by, rd2_by;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_nb), .rdata2(rd2_nb), .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_by (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rd1_by), .rdata2(rd2_by), .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] pre1;
    logic [31:0] pre2;
    logic [31:0] post1;
    logic [31:0] post2;
  } vec_t;

  vec_t vecs [9];

  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Forwarding rule for the BYPASS=1 build, applied on top of the stored value.
  function automatic logic [31:0] fwd(input logic [4:0] ra, input logic [31:0] stored);
    if (ra == 5'd0) return 32'h0;
    if (!rst && wen && waddr == ra) return wdata;
    return stored;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] ra);
    return (ra == 5'd0) ? 32'h0 : model[ra];
  endfunction

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;

    //          rst   wen   waddr  wdata         ra1    ra2    pre1          pre2          post1         post2
    vecs[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd7,  32'h0,        32'h0,        32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 5'd7,  32'h00001234, 5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vecs[2] = '{1'b0, 1'b1, 5'd3,  32'h00000004, 5'd4,  5'd3,  32'h0,        32'h0,        32'h0,        32'h4};
    vecs[3] = '{1'b0, 1'b1, 5'd4,  32'h80000001, 5'd4,  5'd3,  32'h0,        32'h4,        32'h80000001, 32'h4};
    vecs[4] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd4,  32'h0,        32'h80000001, 32'h0,        32'h80000001};
    vecs[5] = '{1'b0, 1'b1, 5'd9,  32'h00000011, 5'd9,  5'd0,  32'h0,        32'h0,        32'h11,       32'h0};
    vecs[6] = '{1'b0, 1'b1, 5'd9,  32'h00000022, 5'd9,  5'd0,  32'h11,       32'h0,        32'h22,       32'h0};
    vecs[7] = '{1'b0, 1'b0, 5'd12, 32'h0000ABCD, 5'd12, 5'd9,  32'h0,        32'h22,       32'h0,        32'h22};
    vecs[8] = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd31, 32'h0,        32'h0,        32'hA5A5A5A5, 32'hA5A5A5A5};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: pre-edge and post-edge reads on both builds.
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
      #1;
      check($sformatf("v%0d pre rdata1", i), rd1_nb, vecs[i].pre1);
      check($sformatf("v%0d pre rdata2", i), rd2_nb, vecs[i].pre2);
      check($sformatf("v%0d byp pre rdata1", i), rd1_by, fwd(vecs[i].ra1, vecs[i].pre1));
      check($sformatf("v%0d byp pre rdata2", i), rd2_by, fwd(vecs[i].ra2, vecs[i].pre2));
      @(posedge clk); #1;
      check($sformatf("v%0d post rdata1", i), rd1_nb, vecs[i].post1);
      check($sformatf("v%0d post rdata2", i), rd2_nb, vecs[i].post2);
    end

    // Hand sequence: bypass forwards same-cycle write, port 2 at r0 stays 0.
    rst = 1'b0; wen = 1'b1; waddr = 5'd9; wdata = 32'h33; raddr1 = 5'd9; raddr2 = 5'd0;
    #1;
    check("bypass same-cycle rdata1", rd1_by, 32'h33);
    check("bypass r0 rdata2", rd2_by, 32'h0);
    check("nobypass old rdata1", rd1_nb, 32'h22);
    @(posedge clk); #1;
    wen = 1'b0;

    // Hand sequence: reset mid-operation, then normal write the next cycle.
    rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 32'h44; raddr1 = 5'd9; raddr2 = 5'd31;
    @(posedge clk); #1;
    check("rst clears r9", rd1_nb, 32'h0);
    check("rst clears r31", rd2_nb, 32'h0);
    rst = 1'b0; wdata = 32'h55;
    @(posedge clk); #1;
    check("post-rst write r9", rd1_nb, 32'h55);
    check("post-rst write r9 byp", rd1_by, 32'h55);

    // Randomized phase against the array model.
    rst = 1'b1; wen = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
    for (int n = 0; n < 300; n++) begin
      rst    = ($urandom_range(0, 40) == 0);
      wen    = $urandom_range(0, 1);
      waddr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wdata  = $urandom;
      raddr1 = ($urandom_range(0, 1) == 0) ? waddr : 5'($urandom_range(0, 3));
      raddr2 = 5'($urandom);
      #1;
      check("rand nb rdata1", rd1_nb, mread(raddr1));
      check("rand nb rdata2", rd2_nb, mread(raddr2));
      check("rand by rdata1", rd1_by, fwd(raddr1, mread(raddr1)));
      check("rand by rdata2", rd2_by, fwd(raddr2, mread(raddr2)));
      if (rst) begin
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
      end else if (wen && waddr != 5'd0) begin
        model[waddr] = wdata;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
